// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one memory port, one transaction at a time, with a response timeout.
// Optional MEM_ARB_RR_EN: round-robin arbitration on simultaneous requests instead of fixed DATA_PRIO.
module mem_port_arbiter #(
   parameter int TIMEOUT   = 64,
   parameter int DATA_PRIO = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_mask,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic       done;
   logic       pick_dm;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr;  // 1 = data preferred on the next tie
   assign pick_dm = rr_ptr;
`else
   assign pick_dm = (DATA_PRIO != 0);
`endif

   // mem_valid on the last counted cycle wins over the timeout
   assign done = (state != IDLE) && (mem_valid || (cnt == TMO_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (if_req && dm_req) state_nxt = pick_dm ? GNT_DM : GNT_IF;
            else if (if_req)      state_nxt = GNT_IF;
            else if (dm_req)      state_nxt = GNT_DM;
         end
         GNT_IF, GNT_DM: if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      if_valid    = (state == GNT_IF) && done;
      dm_valid    = (state == GNT_DM) && done;
      if_rdata    = (if_valid && mem_valid) ? mem_rdata : 32'h0;
      dm_rdata    = (dm_valid && mem_valid) ? mem_rdata : 32'h0;
      timeout_err = busy && !mem_valid && (cnt == TMO_LAST);
   end

   // Grant capture: the winner's request is latched once and held for the whole grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_mask  <= 4'h0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         cnt       <= 8'h0;
`ifdef MEM_ARB_RR_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         if (state == IDLE && state_nxt == GNT_IF) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_mask  <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
         end else if (state == IDLE && state_nxt == GNT_DM) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_mask  <= dm_mask;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
         end else if (done) begin
            mem_req   <= 1'b0;
         end

         if (state != IDLE && !done) cnt <= cnt + 8'd1;
         else                        cnt <= 8'h0;

`ifdef MEM_ARB_RR_EN
         if (done) rr_ptr <= (state == GNT_IF);
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT = 8, DATA_PRIO = 1); tie-break expectation follows MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_mask;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_mask;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        busy;
   logic        timeout_err;

   int n_chk  = 0;
   int n_pass = 0;

   mem_port_arbiter #(.TIMEOUT(8), .DATA_PRIO(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_mask(dm_mask), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int got_id;
   int exp_order [3];
   logic early;

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_mask = 0;
      dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_valid = 0;
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0};
`else
      exp_order = '{1, 1, 1};
`endif

      // reset values
      @(negedge clk); #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mask_we", {27'd0, mem_mask, mem_we}, 32'd0);
      chk("rst_valids", {29'd0, if_valid, dm_valid, timeout_err}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // fetch alone, memory answers in the third grant cycle
      @(negedge clk);
      if_req = 1; if_addr = 32'h0000_0010; #1;
      chk("if_req_latency", {31'd0, mem_req}, 32'd0);
      @(negedge clk); #1;
      chk("if_mem_req", {31'd0, mem_req}, 32'd1);
      chk("if_mask_we", {27'd0, mem_mask, mem_we}, {27'd0, 4'hF, 1'b0});
      chk("if_mem_addr", mem_addr, 32'h10);
      chk("if_busy", {31'd0, busy}, 32'd1);
      @(negedge clk); @(negedge clk);
      mem_valid = 1; mem_rdata = 32'h0000_0013; #1;
      chk("if_valid", {30'd0, if_valid, dm_valid}, 32'b10);
      chk("if_rdata", if_rdata, 32'h13);
      @(negedge clk);
      mem_valid = 0; if_req = 0; #1;
      chk("if_done_busy", {30'd0, busy, mem_req}, 32'd0);
      chk("if_rdata_idle", if_rdata, 32'd0);

      // store with byte mask; requester inputs change mid-grant
      do_reset();
      dm_req = 1; dm_we = 1; dm_mask = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dm_wdata = 32'h1234_5678; dm_mask = 4'hF; #1;
      chk("st_mask_we", {27'd0, mem_mask, mem_we}, {27'd0, 4'b0011, 1'b1});
      chk("st_addr", mem_addr, 32'h100);
      @(negedge clk); #1;
      chk("st_wdata_held", mem_wdata, 32'hDEAD_BEEF);
      chk("st_mask_held", {28'd0, mem_mask}, 32'b0011);
      mem_valid = 1; mem_rdata = 32'h5555_0000; #1;
      chk("st_valid", {30'd0, if_valid, dm_valid}, 32'b01);
      @(negedge clk);
      mem_valid = 0; dm_req = 0; dm_we = 0; #1;
      chk("st_after", {29'd0, dm_valid, busy, mem_req}, 32'd0);

      // simultaneous requests held over three transactions
      do_reset();
      if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_mask = 4'hF; dm_addr = 32'h200;
      for (int n = 0; n < 3; n++) begin
         for (int w = 0; w < 5 && !mem_req; w++) @(negedge clk);
         chk($sformatf("both_grant%0d", n), {31'd0, mem_req}, 32'd1);
         mem_valid = 1; mem_rdata = 32'hA0 + n; #1;
         got_id = dm_valid ? 1 : (if_valid ? 0 : 2);
         chk($sformatf("both_order%0d", n), got_id, exp_order[n]);
         chk($sformatf("both_onehot%0d", n), {31'd0, if_valid & dm_valid}, 32'd0);
         @(negedge clk);
         mem_valid = 0;
      end
      if_req = 0; dm_req = 0;

      // memory never answers: abort on the eighth grant cycle
      do_reset();
      if_req = 1; if_addr = 32'h20; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      chk("tmo_mem_req", {31'd0, mem_req}, 32'd1);
      early = 0;
      for (int c = 0; c < 7; c++) begin
         if (c != 0) begin @(negedge clk); #1; end
         if (timeout_err || if_valid) early = 1;
      end
      chk("tmo_no_early", {31'd0, early}, 32'd0);
      @(negedge clk); #1;
      chk("tmo_pulse", {30'd0, if_valid, timeout_err}, 32'b11);
      chk("tmo_rdata", if_rdata, 32'd0);
      if_req = 0;
      @(negedge clk); #1;
      chk("tmo_idle", {29'd0, busy, mem_req, timeout_err}, 32'd0);

      // response arrives on the last counted cycle: normal completion
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 32'h300;
      @(negedge clk);
      repeat (7) @(negedge clk);
      mem_valid = 1; mem_rdata = 32'hCAFE_0001; #1;
      chk("race_valid", {30'd0, dm_valid, timeout_err}, 32'b10);
      chk("race_rdata", dm_rdata, 32'hCAFE_0001);
      @(negedge clk);
      mem_valid = 0; dm_req = 0;

      // asynchronous reset two cycles into a data grant
      do_reset();
      dm_req = 1; dm_we = 1; dm_mask = 4'h1; dm_addr = 32'h400; dm_wdata = 32'h77;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #2;
      rst = 1; #1;
      chk("arst_out", {29'd0, mem_req, busy, mem_we}, 32'd0);
      chk("arst_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 0; dm_req = 0;
      @(negedge clk);
      mem_valid = 1; mem_rdata = 32'h9999; #1;
      chk("arst_stray", {30'd0, dm_valid, if_valid}, 32'd0);
      @(negedge clk);
      mem_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
